// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int          DATA_WIDTH  = 24;
  localparam int          INSTR_WIDTH = 24;
  localparam logic [3:0]  HALT_OPCODE = 4'hF;
  localparam logic [23:0] NOP_INSTR   = 24'h000000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } fetch_state_t;

  // One IF/ID slot: the word, its address and whether it is real.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instruction;
    logic [DATA_WIDTH-1:0]  pc;
    logic                   valid;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer: parks a returning fetch word while decode is stalled.
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int W = $bits(if_id_t)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_valid
);

  logic [W-1:0] r_data;
  logic         r_valid;

  // Capture on load, drop on clear; clear wins so a redirect always empties it.
  // NOTE: the data register is reset too, so a reset mid-stall can never leak the parked word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, skid buffer, branch redirect and HALT.
// Optional feature: define FETCH_PERF_COUNT_EN to add perf_fetched / perf_stall counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                WIDTH            = 24,
  parameter int                INSTRUCTIONWIDTH = 24,
  parameter int                OPCODEWIDTH      = 4,
  parameter int                PC_STEP          = 1,
  parameter logic [WIDTH-1:0]  RESET_PC         = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall_D,
  input  logic                        branch_taken,
  input  logic [WIDTH-1:0]            branch_target,
  input  logic [INSTRUCTIONWIDTH-1:0] imem_data,
  output logic [WIDTH-1:0]            imem_addr,
  output logic                        imem_rd,
  output logic [INSTRUCTIONWIDTH-1:0] instruction_D,
  output logic [WIDTH-1:0]            PC_D,
  output logic                        valid_D,
  output logic                        halted
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0]                 perf_fetched,
  output logic [31:0]                 perf_stall
`endif
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  fetch_state_t     r_state, w_state_next;
  logic [WIDTH-1:0] r_pc_f;
  logic [WIDTH-1:0] r_pc_inflight;
  logic             r_inflight;
  if_id_t           r_if_id, w_if_id_next;
  logic             r_halted, w_halted_next;
  logic             w_rd;
  logic             w_word_ok;
  logic             w_skid_load, w_skid_clear, w_skid_valid;
  if_id_t           w_skid_data;
  logic             w_ret_halt, w_skid_halt;

  assign imem_addr  = branch_taken ? branch_target : r_pc_f;
  assign imem_rd    = w_rd;
  // A returning word is only usable if a read was issued and fetch has not halted.
  assign w_word_ok  = r_inflight && !r_halted;
  assign w_ret_halt  = (imem_data[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH] == HALT_OPCODE);
  assign w_skid_halt = (w_skid_data.instruction[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH] == HALT_OPCODE);

  fetch_skid_buffer #(.W($bits(if_id_t))) u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  ({imem_data, r_pc_inflight, 1'b1}),
    .o_data  (w_skid_data),
    .o_valid (w_skid_valid)
  );

  // Next-state, read strobe and IF/ID next value; branch redirect overrides everything.
  // NOTE: every signal gets its default first so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_rd          = 1'b0;
    w_if_id_next  = r_if_id;
    w_halted_next = r_halted;
    w_skid_load   = 1'b0;
    w_skid_clear  = 1'b0;
    if (branch_taken) begin
      w_rd                     = 1'b1;
      w_state_next             = RUN;
      w_skid_clear             = 1'b1;
      w_halted_next            = 1'b0;
      w_if_id_next.instruction = NOP_INSTR;
      w_if_id_next.pc          = '0;
      w_if_id_next.valid       = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!stall_D && !r_halted) begin
            w_rd         = 1'b1;
            w_state_next = RUN;
          end
        end
        RUN: begin
          if (!stall_D) begin
            w_rd = !r_halted;
            if (w_word_ok) begin
              w_if_id_next.instruction = imem_data;
              w_if_id_next.pc          = r_pc_inflight;
              w_if_id_next.valid       = 1'b1;
              w_halted_next            = w_ret_halt;
            end else begin
              w_if_id_next.valid = 1'b0;
            end
          end else if (w_word_ok) begin
            w_skid_load  = 1'b1;
            w_state_next = HOLD;
          end
        end
        HOLD: begin
          if (!stall_D) begin
            w_if_id_next       = w_skid_data;
            w_if_id_next.valid = w_skid_valid;
            w_halted_next      = w_skid_valid && w_skid_halt;
            w_skid_clear       = 1'b1;
            w_rd               = !r_halted;
            w_state_next       = RUN;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // PC register and in-flight read tracking; each issued read is consumed the next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc_f        <= RESET_PC;
      r_pc_inflight <= '0;
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      if (w_rd) begin
        r_pc_f        <= imem_addr + STEP;
        r_pc_inflight <= imem_addr;
      end
    end
  end

  // IF/ID pipeline register and halt flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_if_id  <= '0;
      r_halted <= 1'b0;
    end else begin
      r_if_id  <= w_if_id_next;
      r_halted <= w_halted_next;
    end
  end

  assign instruction_D = r_if_id.instruction;
  assign PC_D          = r_if_id.pc;
  assign valid_D       = r_if_id.valid;
  assign halted        = r_halted;

`ifdef FETCH_PERF_COUNT_EN
  logic        w_fetch_load;
  logic [31:0] r_perf_fetched, r_perf_stall;

  assign w_fetch_load = !branch_taken && !stall_D &&
                        (((r_state == RUN) && w_word_ok) || ((r_state == HOLD) && w_skid_valid));

  // Saturating counters of delivered words and stalled cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_fetch_load && (r_perf_fetched != '1)) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (stall_D && (r_perf_stall != '1))        r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected deliveries, monitors pop and compare.
module tb_fetch_stage;

  typedef struct {
    logic [23:0] instr;
    logic [23:0] pc;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  // DUT 0: default RESET_PC
  logic        reset0, stall0, br0;
  logic [23:0] tgt0, data0, addr0, instr0, pc0;
  logic        rd0, valid0, halted0;
  // DUT 1: RESET_PC at the top of the address space
  logic        reset1, stall1, br1;
  logic [23:0] tgt1, data1, addr1, instr1, pc1;
  logic        rd1, valid1, halted1;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] pf0, ps0, pf1, ps1;
`endif

  fetch_stage dut0 (
    .clock(clock), .reset(reset0), .stall_D(stall0), .branch_taken(br0),
    .branch_target(tgt0), .imem_data(data0), .imem_addr(addr0), .imem_rd(rd0),
    .instruction_D(instr0), .PC_D(pc0), .valid_D(valid0), .halted(halted0)
`ifdef FETCH_PERF_COUNT_EN
    , .perf_fetched(pf0), .perf_stall(ps0)
`endif
  );

  fetch_stage #(.RESET_PC(24'hFFFFFF)) dut1 (
    .clock(clock), .reset(reset1), .stall_D(stall1), .branch_taken(br1),
    .branch_target(tgt1), .imem_data(data1), .imem_addr(addr1), .imem_rd(rd1),
    .instruction_D(instr1), .PC_D(pc1), .valid_D(valid1), .halted(halted1)
`ifdef FETCH_PERF_COUNT_EN
    , .perf_fetched(pf1), .perf_stall(ps1)
`endif
  );

  function automatic logic [23:0] mem0(input logic [23:0] a);
    logic [23:0] base = 24'h100000;
    return (a == 24'd5) ? 24'hF00000 : base + a;
  endfunction

  function automatic logic [23:0] mem1(input logic [23:0] a);
    logic [23:0] base = 24'h100000;
    return (a == 24'd1) ? 24'hF00001 : base + a;
  endfunction

  // Synchronous instruction memories, one-cycle read latency.
  always @(posedge clock) begin
    if (rd0) data0 <= mem0(addr0);
    if (rd1) data1 <= mem1(addr1);
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push0(input logic [23:0] pc);
    q0.push_back('{mem0(pc), pc});
  endtask

  task automatic push1(input logic [23:0] pc);
    q1.push_back('{mem1(pc), pc});
  endtask

  // Monitors: a word is consumed by decode when valid and not stalled at the edge.
  always @(negedge clock) begin
    if (!reset0 && valid0 && !stall0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_unexpected actual=%h/%h required=none", instr0, pc0);
      end else begin
        e0 = q0.pop_front();
        check("dut0_word", {instr0, pc0}, {e0.instr, e0.pc});
      end
    end
    if (!reset1 && valid1 && !stall1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected actual=%h/%h required=none", instr1, pc1);
      end else begin
        e1 = q1.pop_front();
        check("dut1_word", {instr1, pc1}, {e1.instr, e1.pc});
      end
    end
  end

  initial begin
    reset0 = 1'b1; stall0 = 1'b0; br0 = 1'b0; tgt0 = '0;
    reset1 = 1'b1; stall1 = 1'b0; br1 = 1'b0; tgt1 = '0;
    step(3);

    // Reset state
    check("rst_valid",  48'(valid0),  48'd0);
    check("rst_instr",  48'(instr0),  48'd0);
    check("rst_pc",     48'(pc0),     48'd0);
    check("rst_halted", 48'(halted0), 48'd0);
    check("rst_addr",   48'(addr0),   48'd0);

    // Streaming from reset; word 5 is HALT
    for (int i = 0; i < 6; i++) push0(24'(i));
    reset0 = 1'b0;
    #1;
    check("idle_rd",   48'(rd0),   48'd1);
    check("idle_addr", 48'(addr0), 48'd0);
    step(1);
    check("e1_valid", 48'(valid0), 48'd0);
    check("e1_addr",  48'(addr0),  48'd1);
    step(1);
    check("e2_valid", 48'(valid0), 48'd1);
    check("e2_pc",    48'(pc0),    48'd0);
    step(2);
    check("e4_pc", 48'(pc0), 48'd2);

    // Three-cycle stall with word 3 parked in the skid
    stall0 = 1'b1;
    #1;
    check("stall_rd", 48'(rd0), 48'd0);
    step(3);
    check("stall_hold_pc", 48'(pc0),  48'd2);
    check("stall_hold_rd", 48'(rd0),  48'd0);
    stall0 = 1'b0;
    #1;
    check("release_rd",   48'(rd0),   48'd1);
    check("release_addr", 48'(addr0), 48'd4);
    step(1);
    check("release_pc3", 48'(pc0), 48'd3);
    step(2);
    check("halt_pc",     48'(pc0),     48'd5);
    check("halt_flag",   48'(halted0), 48'd1);
    check("halt_rd",     48'(rd0),     48'd0);
    step(4);
    check("halted_valid", 48'(valid0),  48'd0);
    check("halted_still", 48'(halted0), 48'd1);
    check("halted_rd",    48'(rd0),     48'd0);

    // Branch out of HALT
    push0(24'h10);
    push0(24'h11);
    br0 = 1'b1; tgt0 = 24'h10;
    #1;
    check("br1_rd",   48'(rd0),   48'd1);
    check("br1_addr", 48'(addr0), 48'h10);
    step(1);
    br0 = 1'b0;
    check("br1_bubble", 48'(valid0),  48'd0);
    check("br1_unhalt", 48'(halted0), 48'd0);
    step(1);
    check("br1_pc", 48'(pc0), 48'h10);
    step(2);
    check("br1_pc12", 48'(pc0), 48'h12);

    // Branch while stalled: word 0x12 and the in-flight 0x13 are squashed
    push0(24'h40);
    push0(24'h41);
    stall0 = 1'b1; br0 = 1'b1; tgt0 = 24'h40;
    #1;
    check("br2_rd",   48'(rd0),   48'd1);
    check("br2_addr", 48'(addr0), 48'h40);
    step(1);
    check("br2_bubble", 48'(valid0), 48'd0);
    check("br2_instr",  48'(instr0), 48'd0);
    br0 = 1'b0; stall0 = 1'b0;
    step(1);
    check("br2_pc", 48'(pc0), 48'h40);
    step(2);
    check("br2_pc42", 48'(pc0), 48'h42);

    // Enter HOLD then reset: skid word 0x43 must never appear
    stall0 = 1'b1;
    step(1);
    check("hold_rd", 48'(rd0), 48'd0);
    reset0 = 1'b1;
    #1;
    check("arst_valid",  48'(valid0),  48'd0);
    check("arst_instr",  48'(instr0),  48'd0);
    check("arst_pc",     48'(pc0),     48'd0);
    check("arst_halted", 48'(halted0), 48'd0);
    check("arst_addr",   48'(addr0),   48'd0);
    stall0 = 1'b0;
    push0(24'd0);
    push0(24'd1);
    step(2);
    reset0 = 1'b0;
    step(2);
    check("rerun_pc0", 48'(pc0), 48'd0);
    step(2);
    check("rerun_pc2", 48'(pc0), 48'd2);
    stall0 = 1'b1;
    reset0 = 1'b1;

    // DUT 1: PC wraps from 0xFFFFFF to 0, HALT at address 1
    push1(24'hFFFFFF);
    push1(24'h000000);
    push1(24'h000001);
    reset1 = 1'b0;
    #1;
    check("wrap_addr0", 48'(addr1), 48'hFFFFFF);
    step(1);
    check("wrap_addr1", 48'(addr1), 48'h000000);
    for (int i = 0; i < 20 && q1.size() != 0; i++) step(1);
    step(4);
    check("wrap_halted", 48'(halted1), 48'd1);
    check("wrap_rd",     48'(rd1),     48'd0);
    check("wrap_valid",  48'(valid1),  48'd0);

    check("q0_drained", 48'(q0.size()), 48'd0);
    check("q1_drained", 48'(q1.size()), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
